// File: rtl/dmem_pkg.sv
// Shared constants for the wait-state data memory responder:
// FSM encoding, debug register map and the word range check.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] DBG_READS     = 6'd0;
  localparam logic [5:0] DBG_WRITES    = 6'd1;
  localparam logic [5:0] DBG_ERRORS    = 6'd2;
  localparam logic [5:0] DBG_LAST_ADDR = 6'd3;
  localparam logic [5:0] DBG_STATE     = 6'd4;

  function automatic logic word_in_range(
    input logic [29:0] widx,
    input int unsigned depth
  );
    return {2'b00, widx} < depth;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word storage with byte-lane write enables,
// synchronous write and combinational read.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: FSM, request latches, range check.
// Define DMEM_DEBUG_EN to add the debug_addr/debug_data counter port.
module dmem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        busy
`ifdef DMEM_DEBUG_EN
  ,
  input  logic [5:0]  debug_addr,
  output logic [31:0] debug_data
`endif
);

  import dmem_pkg::*;

  localparam int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  logic [1:0]  state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        idle;
  logic        start;
  logic        go_done;
  logic        acc_we;
  logic [3:0]  acc_be;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_ok;
  logic        addr_ok_q;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        unused_lsb;

  assign idle  = (state_q == ST_IDLE);
  assign start = idle && mem_req;

  // With no wait states the write lands on the accepting edge,
  // before the latches hold the request, so use the live inputs.
  assign acc_we    = idle ? mem_we    : we_q;
  assign acc_be    = idle ? mem_be    : be_q;
  assign acc_addr  = idle ? mem_addr  : addr_q;
  assign acc_wdata = idle ? mem_wdata : wdata_q;

  assign go_done = (start && NO_WAIT) ||
                   ((state_q == ST_WAIT) && (cnt_q == 4'd1));

  assign acc_ok = word_in_range(acc_addr[31:2], DEPTH_WORDS);
  assign ram_we = go_done && acc_we && acc_ok && !rst;

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (acc_be),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_req) begin
            state_q <= NO_WAIT ? ST_DONE : ST_WAIT;
            cnt_q   <= 4'(WAIT_CYCLES);
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      we_q    <= mem_we;
      be_q    <= mem_be;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  assign addr_ok_q = word_in_range(addr_q[31:2], DEPTH_WORDS);
  assign busy      = !idle;
  assign mem_ack   = (state_q == ST_DONE);
  assign mem_err   = mem_ack && !addr_ok_q;
  assign mem_rdata = (mem_ack && !we_q && addr_ok_q) ? ram_rdata : '0;

  assign unused_lsb = ^addr_q[1:0];

`ifdef DMEM_DEBUG_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;
  logic [31:0] er_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      er_cnt_q <= '0;
    end else if (mem_ack) begin
      if (we_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      else      rd_cnt_q <= rd_cnt_q + 32'd1;
      if (mem_err) er_cnt_q <= er_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      debug_data <= '0;
    end else begin
      case (debug_addr)
        DBG_READS:     debug_data <= rd_cnt_q;
        DBG_WRITES:    debug_data <= wr_cnt_q;
        DBG_ERRORS:    debug_data <= er_cnt_q;
        DBG_LAST_ADDR: debug_data <= addr_q;
        DBG_STATE:     debug_data <= {30'b0, state_q};
        default:       debug_data <= 32'hFFFF_FFFF;
      endcase
    end
  end
`endif

endmodule
